mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: none; bus widths come from the shared header: MS_TO_WS_BUS_WD = 70, ES_TO_MS_BUS_WD = 74.
REQ-002 clk  input  1  sole clock; all state on posedge clk.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 ms_allowin  output  1  stage can accept a new instruction this cycle.
REQ-005 es_to_ms_valid  input  1  EX stage presents a valid instruction.
REQ-006 es_to_ms_bus  input  74  fields, MSB first:
  - res_from_mem[73]
  - ld_type[72:70]: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
  - gr_we[69]
  - dest[68:64]
  - alu_result[63:32] (load address)
  - pc[31:0]
REQ-007 data_sram_data_ok  input  1  read data for the oldest outstanding load is valid this cycle.
REQ-008 data_sram_rdata  input  32  load read data, valid with data_ok.
REQ-009 ws_allowin  input  1  WB stage can accept.
REQ-010 ms_to_ws_valid  output  1  valid instruction offered to WB.
REQ-011 ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-012 ms_to_ds_bus  output  39  {ms_valid&gr_we[38], load_pending[37], dest[36:32], final_result[31:0]}; only driven under MS_FWD_EN.

Function
REQ-013 Handshake: ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin). Transfer to WB occurs when ms_to_ws_valid & ws_allowin.
REQ-014 Capture: when ms_allowin, ms_valid <= es_to_ms_valid. The bus register loads only when es_to_ms_valid & ms_allowin.
REQ-015 State machine, three states: EMPTY, WAIT_DATA, READY.
  - EMPTY: on accept, go to WAIT_DATA if res_from_mem=1, else READY.
  - WAIT_DATA: on data_ok, go to READY and latch rdata into rdata_buf.
  - READY: on transfer to WB, go to EMPTY if no new accept; on a same-cycle accept, re-enter WAIT_DATA or READY per the new instruction.
REQ-016 Ready-go: ms_ready_go = 1 in READY and 0 in WAIT_DATA. No zero-cycle bypass of data_ok; load latency through the stage is a minimum of 1 cycle after data_ok.
REQ-017 ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-018 Load extraction uses byte offset a = alu_result[1:0].
  - lb/lbu: byte rdata_buf[8a+7:8a], sign- or zero-extended to 32 bits.
  - lh/lhu: half rdata_buf[16a[1]+15:16a[1]]; a[0] is ignored.
  - lw: full word.
  - Undefined ld_type codes (101-111) are treated as lw.
REQ-019 final_result = extracted load data if res_from_mem, else alu_result.
REQ-020 data_ok arriving in EMPTY or READY is discarded; state and rdata_buf are unchanged.
REQ-021 Back-pressure: READY with ws_allowin=0 holds the bus and rdata_buf stable indefinitely, and ms_allowin stays 0.
REQ-022 Simultaneous transfer-out and accept-in in the same cycle is legal and produces no bubble.

Reset
REQ-023 resetn low asynchronously clears ms_valid to 0 and state to EMPTY; ms_allowin reads 1 and ms_to_ws_valid reads 0 during reset.
REQ-024 The bus register and rdata_buf are not reset. Outputs derived from them are don't-care while ms_valid=0, except that ms_to_ds_bus[38:37] = 0.
REQ-025 Reset asserted in WAIT_DATA abandons the load; a data_ok arriving after release is discarded per REQ-020.

Configuration
REQ-026 Macro MS_FWD_EN.
  - Defined: ms_to_ds_bus carries live forwarding info. load_pending = ms_valid & (state==WAIT_DATA).
  - Undefined: ms_to_ds_bus is tied to all zeros and the extraction logic feeds only ms_to_ws_bus.

Verification
REQ-027 Non-load: alu_result=0x12345678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_bus = {1, 5, 0x12345678, pc} with ms_to_ws_valid=1.
REQ-028 lb at addr 0x...03 with data_ok and rdata=0x80FF0011 one cycle after accept -> final_result=0xFFFFFF80. Same stimulus with lbu -> 0x00000080.
REQ-029 lh at addr 0x...02 with rdata=0x8001_7FFF -> 0xFFFF8001. lhu with the same data -> 0x00008001.
REQ-030 Load with data_ok delayed 5 cycles -> ms_to_ws_valid=0 and ms_allowin=0 for 5 cycles; with MS_FWD_EN, load_pending=1 throughout.
REQ-031 READY with ws_allowin=0 for 3 cycles and a stray data_ok=0xDEADBEEF mid-stall -> bus unchanged and final_result keeps the original data.
REQ-032 resetn pulsed low in WAIT_DATA, then data_ok after release -> state EMPTY and ms_to_ws_valid never asserts.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and data bus bundle between the EX, MEM and WB pipeline stages.
// The MEM stage uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface mem_stage_if;
  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 39;

  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;

  modport master (
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_to_ds_bus,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output data_sram_data_ok,
    output data_sram_rdata,
    output ws_allowin
  );

  modport slave (
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_to_ds_bus,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    input  ws_allowin
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for load data, extracts/extends bytes and halves, hands off to WB.
// Optional macro MS_FWD_EN drives live forwarding info on ms_to_ds_bus (otherwise tied to zero).
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus_if
);

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 39;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_DATA = 2'd1,
    READY     = 2'd2
  } state_t;

  state_t                     state;
  state_t                     accept_state;
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [31:0]                rdata_buf;

  logic        ms_ready_go;
  logic        ms_allowin;
  logic        accept;
  logic        transfer;

  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  assign {res_from_mem, ld_type, gr_we, dest, alu_result, pc} = es_bus_r;
  assign addr_lo = alu_result[1:0];

  assign ms_ready_go = (state == READY);
  assign ms_allowin  = ~ms_valid | (ms_ready_go & bus_if.ws_allowin);
  assign accept      = bus_if.es_to_ms_valid & ms_allowin;
  assign transfer    = ms_valid & ms_ready_go & bus_if.ws_allowin;

  // Where a freshly accepted instruction lands depends on whether it needs memory data.
  assign accept_state = bus_if.es_to_ms_bus[ES_TO_MS_BUS_WD-1] ? WAIT_DATA : READY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      state    <= EMPTY;
    end else begin
      if (ms_allowin) begin
        ms_valid <= bus_if.es_to_ms_valid;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= accept_state;
          end
        end
        WAIT_DATA: begin
          if (bus_if.data_sram_data_ok) begin
            state <= READY;
          end
        end
        READY: begin
          if (transfer) begin
            state <= accept ? accept_state : EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset; a data_ok outside WAIT_DATA must not disturb rdata_buf.
  always_ff @(posedge clk) begin
    if (accept) begin
      es_bus_r <= bus_if.es_to_ms_bus;
    end
    if ((state == WAIT_DATA) && bus_if.data_sram_data_ok) begin
      rdata_buf <= bus_if.data_sram_rdata;
    end
  end

  always_comb begin
    ld_byte = rdata_buf[7:0];
    case (addr_lo)
      2'd0:    ld_byte = rdata_buf[7:0];
      2'd1:    ld_byte = rdata_buf[15:8];
      2'd2:    ld_byte = rdata_buf[23:16];
      default: ld_byte = rdata_buf[31:24];
    endcase
  end

  assign ld_half = addr_lo[1] ? rdata_buf[31:16] : rdata_buf[15:0];

  // Reserved ld_type codes fall through to a full-word load.
  always_comb begin
    ld_data = rdata_buf;
    case (ld_type)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {24'd0, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_data = {16'd0, ld_half};
      LD_LW:   ld_data = rdata_buf;
      default: ld_data = rdata_buf;
    endcase
  end

  assign final_result = res_from_mem ? ld_data : alu_result;

  assign bus_if.ms_allowin     = ms_allowin;
  assign bus_if.ms_to_ws_valid = ms_valid & ms_ready_go;
  assign bus_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_EN
  logic load_pending;
  assign load_pending        = ms_valid & (state == WAIT_DATA);
  assign bus_if.ms_to_ds_bus = {ms_valid & gr_we, load_pending, dest, final_result};
`else
  assign bus_if.ms_to_ds_bus = {MS_TO_DS_BUS_WD{1'b0}};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, ALU pass-through, load extraction,
// delayed data, back-pressure with a stray data_ok, back-to-back flow and reset mid-load.
module tb_mem_stage;

  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [73:0] es_bus(input logic rfm, input logic [2:0] lt, input logic gw,
                                         input logic [4:0] d, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {rfm, lt, gw, d, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus_if.es_to_ms_valid    = 1'b0;
    bus_if.es_to_ms_bus      = '0;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = '0;
    bus_if.ws_allowin        = 1'b1;
    #12;
    tests_run++;
    if (bus_if.ms_allowin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_allowin: got %b expected 1", bus_if.ms_allowin);
    end
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus_if.ms_to_ws_valid);
    end
    tests_run++;
    if (bus_if.ms_to_ds_bus[38:37] !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ds_flags: got %b expected 00", bus_if.ms_to_ds_bus[38:37]);
    end
    resetn = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got valid=%b allowin=%b expected valid=0 allowin=1",
               bus_if.ms_to_ws_valid, bus_if.ms_allowin);
    end
  endtask

  task automatic test_non_load();
    logic [38:0] exp_ds;
    bus_if.ws_allowin     = 1'b1;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b0, 3'b000, 1'b1, 5'd5, 32'h12345678, 32'h1C000000);
    tick();
    bus_if.es_to_ms_valid = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL alu_valid: got %b expected 1", bus_if.ms_to_ws_valid);
    end
    tests_run++;
    if (bus_if.ms_to_ws_bus !== {1'b1, 5'd5, 32'h12345678, 32'h1C000000}) begin
      tests_failed++;
      $display("[TB] FAIL alu_bus: got %h expected %h", bus_if.ms_to_ws_bus,
               {1'b1, 5'd5, 32'h12345678, 32'h1C000000});
    end
`ifdef MS_FWD_EN
    exp_ds = {1'b1, 1'b0, 5'd5, 32'h12345678};
`else
    exp_ds = 39'd0;
`endif
    tests_run++;
    if (bus_if.ms_to_ds_bus !== exp_ds) begin
      tests_failed++;
      $display("[TB] FAIL alu_ds_bus: got %h expected %h", bus_if.ms_to_ds_bus, exp_ds);
    end
    tick();
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alu_drain: got %b expected 0", bus_if.ms_to_ws_valid);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] lt, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expected);
    logic [69:0] exp_bus;
    exp_bus = {1'b1, 5'd9, expected, 32'h1C000040};
    bus_if.ws_allowin     = 1'b1;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b1, lt, 1'b1, 5'd9, addr, 32'h1C000040);
    tick();
    bus_if.es_to_ms_valid = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_wait: got valid=%b allowin=%b expected 0 0", name,
               bus_if.ms_to_ws_valid, bus_if.ms_allowin);
    end
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = rdata;
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = 32'h0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b1 || bus_if.ms_to_ws_bus !== exp_bus) begin
      tests_failed++;
      $display("[TB] FAIL %s_result: got valid=%b bus=%h expected valid=1 bus=%h", name,
               bus_if.ms_to_ws_valid, bus_if.ms_to_ws_bus, exp_bus);
    end
    tick();
  endtask

  task automatic test_load_delay();
    bus_if.ws_allowin     = 1'b1;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b1, 3'b000, 1'b1, 5'd7, 32'h00000010, 32'h1C000080);
    tick();
    bus_if.es_to_ms_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL delay_wait_%0d: got valid=%b allowin=%b expected 0 0", i,
                 bus_if.ms_to_ws_valid, bus_if.ms_allowin);
      end
`ifdef MS_FWD_EN
      tests_run++;
      if (bus_if.ms_to_ds_bus[37] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL delay_pending_%0d: got %b expected 1", i, bus_if.ms_to_ds_bus[37]);
      end
`endif
      if (i == 4) begin
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hA5A5C3C3;
      end
      tick();
    end
    bus_if.data_sram_data_ok = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b1 || bus_if.ms_to_ws_bus[63:32] !== 32'hA5A5C3C3) begin
      tests_failed++;
      $display("[TB] FAIL delay_result: got valid=%b data=%h expected valid=1 data=a5a5c3c3",
               bus_if.ms_to_ws_valid, bus_if.ms_to_ws_bus[63:32]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [69:0] exp_bus;
    exp_bus = {1'b1, 5'd3, 32'h000000AB, 32'h1C0000C0};
    bus_if.ws_allowin     = 1'b0;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b1, 3'b010, 1'b1, 5'd3, 32'h00000201, 32'h1C0000C0);
    tick();
    bus_if.es_to_ms_valid    = 1'b0;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0000AB00;
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.es_to_ms_valid    = 1'b1;
    bus_if.es_to_ms_bus      = es_bus(1'b0, 3'b000, 1'b1, 5'd30, 32'h55555555, 32'h1C0000C4);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus_if.ms_to_ws_valid !== 1'b1 || bus_if.ms_allowin !== 1'b0 ||
          bus_if.ms_to_ws_bus !== exp_bus) begin
        tests_failed++;
        $display("[TB] FAIL stall_%0d: got valid=%b allowin=%b bus=%h expected 1 0 %h", i,
                 bus_if.ms_to_ws_valid, bus_if.ms_allowin, bus_if.ms_to_ws_bus, exp_bus);
      end
      bus_if.data_sram_data_ok = (i == 1);
      bus_if.data_sram_rdata   = 32'hDEADBEEF;
      tick();
    end
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.es_to_ms_valid    = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_bus !== exp_bus) begin
      tests_failed++;
      $display("[TB] FAIL stall_after_stray: got %h expected %h", bus_if.ms_to_ws_bus, exp_bus);
    end
    bus_if.ws_allowin = 1'b1;
    tick();
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got %b expected 0", bus_if.ms_to_ws_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.ws_allowin     = 1'b1;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b0, 3'b000, 1'b1, 5'd1, 32'h11111111, 32'h1C000100);
    tick();
    bus_if.es_to_ms_bus   = es_bus(1'b0, 3'b000, 1'b0, 5'd2, 32'h22222222, 32'h1C000104);
    tests_run++;
    if (bus_if.ms_allowin !== 1'b1 || bus_if.ms_to_ws_bus !== {1'b1, 5'd1, 32'h11111111, 32'h1C000100}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got allowin=%b bus=%h expected allowin=1 bus=%h",
               bus_if.ms_allowin, bus_if.ms_to_ws_bus, {1'b1, 5'd1, 32'h11111111, 32'h1C000100});
    end
    tick();
    bus_if.es_to_ms_bus   = es_bus(1'b1, 3'b000, 1'b1, 5'd4, 32'h00000100, 32'h1C000108);
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b1 || bus_if.ms_to_ws_bus !== {1'b0, 5'd2, 32'h22222222, 32'h1C000104}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got valid=%b bus=%h expected valid=1 bus=%h",
               bus_if.ms_to_ws_valid, bus_if.ms_to_ws_bus, {1'b0, 5'd2, 32'h22222222, 32'h1C000104});
    end
    tick();
    bus_if.es_to_ms_valid = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_load_wait: got valid=%b allowin=%b expected 0 0",
               bus_if.ms_to_ws_valid, bus_if.ms_allowin);
    end
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'hCAFEF00D;
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    tests_run++;
    if (bus_if.ms_to_ws_valid !== 1'b1 || bus_if.ms_to_ws_bus !== {1'b1, 5'd4, 32'hCAFEF00D, 32'h1C000108}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_load: got valid=%b bus=%h expected valid=1 bus=%h",
               bus_if.ms_to_ws_valid, bus_if.ms_to_ws_bus, {1'b1, 5'd4, 32'hCAFEF00D, 32'h1C000108});
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    bus_if.ws_allowin     = 1'b1;
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = es_bus(1'b1, 3'b000, 1'b1, 5'd6, 32'h00000200, 32'h1C000200);
    tick();
    bus_if.es_to_ms_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus_if.ms_allowin !== 1'b1 || bus_if.ms_to_ws_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_async: got allowin=%b valid=%b expected 1 0",
               bus_if.ms_allowin, bus_if.ms_to_ws_valid);
    end
    #1;
    resetn = 1'b1;
    tick();
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0BADF00D;
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rst_wait_after_%0d: got valid=%b allowin=%b expected 0 1", i,
                 bus_if.ms_to_ws_valid, bus_if.ms_allowin);
      end
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_non_load();
    test_load("lb",    3'b001, 32'h00001003, 32'h80FF0011, 32'hFFFFFF80);
    test_load("lbu",   3'b010, 32'h00001003, 32'h80FF0011, 32'h00000080);
    test_load("lb0",   3'b001, 32'h00001000, 32'h80FF0011, 32'h00000011);
    test_load("lh",    3'b011, 32'h00001002, 32'h80017FFF, 32'hFFFF8001);
    test_load("lhu",   3'b100, 32'h00001002, 32'h80017FFF, 32'h00008001);
    test_load("lh_lo", 3'b011, 32'h00001001, 32'h80017FFF, 32'h00007FFF);
    test_load("lw",    3'b000, 32'h00001000, 32'h13579BDF, 32'h13579BDF);
    test_load("ld111", 3'b111, 32'h00001002, 32'h89ABCDEF, 32'h89ABCDEF);
    test_load_delay();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
